// File: rtl/vga_pkg.sv
// Shared 640x480 raster constants so the timing generator and the controller's
// address arithmetic (x + WIDTH*y) always agree.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int VGA_WIDTH   = 640;
    localparam int VGA_HEIGHT  = 480;
    localparam int VGA_H_FRONT = 16;
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BACK  = 48;
    localparam int VGA_V_FRONT = 10;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BACK  = 33;

    function automatic int raster_total(input int visible, input int front,
                                        input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    localparam int VGA_H_TOTAL = raster_total(VGA_WIDTH, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
    localparam int VGA_V_TOTAL = raster_total(VGA_HEIGHT, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

endpackage

// File: rtl/vga_mod_counter.sv
// Modulo-MOD counter with enable and wrap strobe; wrap_o is combinational, same cycle as the count.
// No backpressure: advances on every enabled edge, cleared asynchronously.
module vga_mod_counter
    import vga_pkg::*;
#(
    parameter int MOD = VGA_H_TOTAL,
    parameter int W   = CNT_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wrap_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing: pixel/line counters with sync, active and end-of-frame decodes, all zero-latency
// from the counters. No backpressure: free-running on clk25, cleared asynchronously by reset.
module vga_timing_generator
    import vga_pkg::*;
#(
    parameter int WIDTH   = VGA_WIDTH,
    parameter int HEIGHT  = VGA_HEIGHT,
    parameter int H_FRONT = VGA_H_FRONT,
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BACK  = VGA_H_BACK,
    parameter int V_FRONT = VGA_V_FRONT,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BACK  = VGA_V_BACK
) (
    input  logic             clk25,
    input  logic             reset,
    output logic [CNT_W-1:0] x,
    output logic [8:0]       y,
    output logic             active,
    output logic             hSync,
    output logic             vSync,
    output logic             screenEnd
);

    localparam int H_TOTAL = raster_total(WIDTH, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = raster_total(HEIGHT, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(WIDTH + H_FRONT);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(WIDTH + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(HEIGHT);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(HEIGHT + V_FRONT);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(HEIGHT + V_FRONT + V_SYNC);

    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             h_wrap;
    logic             unused_v_wrap;

    vga_mod_counter #(.MOD(H_TOTAL), .W(CNT_W)) u_hcnt (
        .clk_i  (clk25),
        .rst_ni (reset),
        .en_i   (1'b1),
        .cnt_o  (hcount),
        .wrap_o (h_wrap)
    );

    // The line counter steps on the pixel wrap, so both wrap together at frame end.
    vga_mod_counter #(.MOD(V_TOTAL), .W(CNT_W)) u_vcnt (
        .clk_i  (clk25),
        .rst_ni (reset),
        .en_i   (h_wrap),
        .cnt_o  (vcount),
        .wrap_o (unused_v_wrap)
    );

    // y deliberately aliases on blanking lines >= 512; consumers qualify with active.
    assign x         = hcount;
    assign y         = vcount[8:0];
    assign active    = (hcount < H_ACT) && (vcount < V_ACT);
    assign hSync     = !((hcount >= HS_BEG) && (hcount < HS_END));
    assign vSync     = !((vcount >= VS_BEG) && (vcount < VS_END));
    assign screenEnd = (hcount == H_ACT - 1'b1) && (vcount == V_ACT - 1'b1);

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: full-size, scaled-down and tall-narrow instances checked every
// cycle against a pixel-index model, plus targeted edge/strobe/alias checks and random async resets.
module tb_vga_timing_generator;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [9:0] x_a, x_b, x_c;
    logic [8:0] y_a, y_b, y_c;
    logic act_a, hs_a, vs_a, se_a;
    logic act_b, hs_b, vs_b, se_b;
    logic act_c, hs_c, vs_c, se_c;

    vga_timing_generator dut_a (
        .clk25(clk), .reset(rst_a), .x(x_a), .y(y_a), .active(act_a),
        .hSync(hs_a), .vSync(vs_a), .screenEnd(se_a)
    );

    vga_timing_generator #(
        .WIDTH(8), .HEIGHT(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) dut_b (
        .clk25(clk), .reset(rst_b), .x(x_b), .y(y_b), .active(act_b),
        .hSync(hs_b), .vSync(vs_b), .screenEnd(se_b)
    );

    vga_timing_generator #(
        .WIDTH(4), .HEIGHT(500), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_FRONT(10), .V_SYNC(2), .V_BACK(13)
    ) dut_c (
        .clk25(clk), .reset(rst_c), .x(x_c), .y(y_c), .active(act_c),
        .hSync(hs_c), .vSync(vs_c), .screenEnd(se_c)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {x,y,active,hSync,vSync,screenEnd} after n rising edges since reset release.
    function automatic logic [22:0] model(input int n, input int w, input int h,
                                          input int hf, input int hs, input int hb,
                                          input int vf, input int vs, input int vb);
        int ht, vt, hc, vc;
        logic a, hsn, vsn, se;
        ht  = w + hf + hs + hb;
        vt  = h + vf + vs + vb;
        hc  = n % ht;
        vc  = (n / ht) % vt;
        a   = (hc < w) && (vc < h);
        hsn = !((hc >= w + hf) && (hc < w + hf + hs));
        vsn = !((vc >= h + vf) && (vc < h + vf + vs));
        se  = (hc == w - 1) && (vc == h - 1);
        return {10'(hc), 9'(vc % 512), a, hsn, vsn, se};
    endfunction

    int n_a = 0, n_b = 0, n_c = 0;
    always @(posedge clk or negedge rst_a) if (!rst_a) n_a <= 0; else n_a <= n_a + 1;
    always @(posedge clk or negedge rst_b) if (!rst_b) n_b <= 0; else n_b <= n_b + 1;
    always @(posedge clk or negedge rst_c) if (!rst_c) n_c <= 0; else n_c <= n_c + 1;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_cycle", int'({x_a, y_a, act_a, hs_a, vs_a, se_a}),
                int'(model(n_a, 640, 480, 16, 96, 48, 10, 2, 33)));
            chk("b_cycle", int'({x_b, y_b, act_b, hs_b, vs_b, se_b}),
                int'(model(n_b, 8, 4, 1, 2, 1, 1, 1, 1)));
            chk("c_cycle", int'({x_c, y_c, act_c, hs_c, vs_c, se_c}),
                int'(model(n_c, 4, 500, 1, 1, 1, 10, 2, 13)));
        end
    end

    localparam logic [22:0] RST_VEC = {10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        int cnt, se_cnt, se_p0, se_p1, vs_first, vs_len;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        #7;
        chk("a_rst_x", x_a, 0);
        chk("a_rst_y", y_a, 0);
        chk("a_rst_active", act_a, 1);
        chk("a_rst_hsync", hs_a, 1);
        chk("a_rst_vsync", vs_a, 1);
        chk("a_rst_screenend", se_a, 0);
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        chk_en = 1'b1;

        // Full-size line: active boundary, hSync window, line wrap
        repeat (639) @(negedge clk);
        chk("a_x639", x_a, 639);
        chk("a_act639", act_a, 1);
        @(negedge clk);
        chk("a_x640", x_a, 640);
        chk("a_act640", act_a, 0);
        for (int i = 0; i < 200 && hs_a; i++) @(negedge clk);
        chk("a_hs_fall_x", x_a, 656);
        cnt = 0;
        for (int i = 0; i < 200 && !hs_a; i++) begin
            @(negedge clk);
            cnt++;
        end
        chk("a_hs_rise_x", x_a, 752);
        chk("a_hs_low_len", cnt, 96);
        for (int i = 0; i < 100 && x_a != 10'd799; i++) @(negedge clk);
        chk("a_x799", x_a, 799);
        @(negedge clk);
        chk("a_wrap_x", x_a, 0);
        chk("a_wrap_y", y_a, 1);

        // Mid-line async reset, asserted between edges
        repeat (300) @(negedge clk);
        chk("a_pre_rst_x", x_a, 300);
        @(posedge clk);
        #5 rst_a = 1'b0;
        #1;
        chk("a_async_rst", int'({x_a, y_a, act_a, hs_a, vs_a, se_a}), int'(RST_VEC));
        @(negedge clk);
        rst_a = 1'b1;
        repeat (5) @(negedge clk);
        chk("a_restart_x", x_a, 5);
        chk("a_restart_y", y_a, 0);

        // Scaled instance: two frames of screenEnd / vSync / wrap
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
        se_cnt = 0; se_p0 = -1; se_p1 = -1; vs_first = -1; vs_len = 0;
        for (int c = 0; c < 168; c++) begin
            if (c > 0) @(negedge clk);
            if (se_b) begin
                se_cnt++;
                if (se_p0 < 0) se_p0 = c; else se_p1 = c;
                chk("b_se_x", x_b, 7);
                chk("b_se_y", y_b, 3);
            end
            if (!vs_b && c < 84) begin
                if (vs_first < 0) begin
                    vs_first = c;
                    chk("b_vs_start_x", x_b, 0);
                    chk("b_vs_start_y", y_b, 5);
                end
                vs_len++;
            end
            if (c == 83) chk("b_last_xy", int'({x_b, y_b}), int'({10'd11, 9'd6}));
            if (c == 84) chk("b_wrap_xy", int'({x_b, y_b}), int'({10'd0, 9'd0}));
        end
        chk("b_se_count", se_cnt, 2);
        chk("b_se_first", se_p0, 43);
        chk("b_se_spacing", se_p1 - se_p0, 84);
        chk("b_vs_len", vs_len, 12);

        // Tall instance: y aliases 0..12 on lines 512..524
        rst_c = 1'b0;
        @(negedge clk);
        rst_c = 1'b1;
        for (int c = 0; c < 3676; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 3583) chk("c_y511", y_c, 511);
            if (c == 3584) chk("c_alias_512", y_c, 0);
            if (c == 3674) chk("c_alias_524", int'({x_c, y_c}), int'({10'd6, 9'd12}));
            if (c == 3675) chk("c_frame_wrap", int'({x_c, y_c}), 0);
        end

        // Random async resets on the scaled instance
        for (int it = 0; it < 8; it++) begin
            repeat ($urandom_range(150, 1)) @(negedge clk);
            @(posedge clk);
            #($urandom_range(17, 2)) rst_b = 1'b0;
            #1;
            chk("b_rand_async_rst", int'({x_b, y_b, act_b, hs_b, vs_b, se_b}), int'(RST_VEC));
            @(negedge clk);
            repeat ($urandom_range(3, 0)) @(negedge clk);
            rst_b = 1'b1;
        end
        repeat (100) @(negedge clk);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
# vga_timing_generator

Raster timing generator for the 640×480 display path. Runs off the 25 MHz pixel-clock enable domain that the VGA controller derives by dividing the system clock by 4. Produces horizontal/vertical sync, a visible-area qualifier, pixel coordinates and an end-of-frame strobe. The controller uses these to address its image/palette memories (the separate `VGA_RAM` block) and to overlay sprites and waveforms.

## Interface
Parameters:
- `WIDTH`, 640, visible pixels per line
- `HEIGHT`, 480, visible lines per frame
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines)

Ports:
- `clk25`  in  1  pixel clock; one clock, all state on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `x`  out  10  horizontal counter `hcount`
- `y`  out  9  vertical counter `vcount[8:0]`
- `active`  out  1  high inside the visible area
- `hSync`  out  1  horizontal sync, active low
- `vSync`  out  1  vertical sync, active low
- `screenEnd`  out  1  one-cycle strobe on the last visible pixel of a frame

## Operation
- Derived constants:
  - H_TOTAL = WIDTH+H_FRONT+H_SYNC+H_BACK (800)
  - V_TOTAL = HEIGHT+V_FRONT+V_SYNC+V_BACK (525)
- `hcount` is 10 bits, 0..H_TOTAL-1. It increments every clock and wraps H_TOTAL-1 → 0.
- `vcount` is 10 bits, 0..V_TOTAL-1. It increments only on the clock where `hcount` wraps, and wraps V_TOTAL-1 → 0 on the same edge that `hcount` wraps.
- `x` = `hcount`. `y` = `vcount[8:0]`.
  - `y` aliases during the blanking lines 512..524, showing 0..12 there.
  - Consumers must qualify `x`/`y` with `active`.
- `active` = (`hcount` < WIDTH) && (`vcount` < HEIGHT).
- `hSync` = 0 iff WIDTH+H_FRONT ≤ `hcount` < WIDTH+H_FRONT+H_SYNC (656..751), else 1.
- `vSync` = 0 iff HEIGHT+V_FRONT ≤ `vcount` < HEIGHT+V_FRONT+V_SYNC (490..491), else 1.
- `screenEnd` = (`hcount` == WIDTH-1) && (`vcount` == HEIGHT-1). It asserts exactly once per frame.
- All outputs are combinational decodes of the two counter registers. There are no other state elements.

## Timing
- Reset (`reset` = 0) clears both counters immediately, without waiting for a clock. While reset is held:
  - `x` = 0, `y` = 0
  - `active` = 1, `hSync` = 1, `vSync` = 1, `screenEnd` = 0
- After reset deasserts, the first rising edge moves `x` to 1.
- Latency:
  - All outputs change in the same cycle as the counter that drives them; there is no pipeline skew between coordinates and syncs.
  - Downstream memories with one-cycle read latency must compensate themselves.
- Line period: 800 clocks.
  - `active` is high for clocks 0..639 of each visible line.
  - `hSync` is low for 96 consecutive clocks starting at `hcount` = 656.
- Frame period: 525 × 800 = 420 000 clocks.
  - `vSync` is low for exactly 1600 consecutive clocks, starting at `hcount` = 0 of line 490.
- Simultaneous wrap: at `hcount` = 799 with `vcount` = 524, the next edge gives `hcount` = 0 and `vcount` = 0.
- Reset mid-frame: counters return to 0 asynchronously, and the frame restarts from pixel (0,0) after release.

## Structure
- The timing constants and the derived H_TOTAL/V_TOTAL belong in a shared `vga_pkg`, so the controller's address arithmetic (`x + 640*y`) and this block agree.
- One sub-module is natural: `vga_mod_counter` (parameterised modulus, enable input, wrap output, async active-low clear). Instantiate it twice, with the horizontal wrap driving the vertical enable.
- `VGA_RAM` (synchronous-read ROM initialised from a mem file) is a separate block and is not part of this unit.

## Test plan
- Hold `reset` low, then release. While low, check `x`=0, `y`=0, `active`=1, `hSync`=1, `vSync`=1, `screenEnd`=0. After 639 clocks, check `x`=639 and `active`=1. After 640 clocks, check `x`=640 and `active`=0.
- Across one line:
  - `hSync` falls at `x`=656 and rises at `x`=752.
  - At `x`=799 the next clock gives `x`=0 and `y`=1.
- Run one full frame:
  - `vSync` is low for exactly 1600 clocks, starting at `y`=490, `x`=0.
  - `y` reads 0..12 during lines 512..524.
  - Wrap to (0,0) occurs at clock 420 000.
- Count `screenEnd` over two frames:
  - Exactly 2 one-cycle pulses, each at `x`=639, `y`=479, spaced 420 000 clocks apart.
- Assert `reset` asynchronously mid-frame (e.g. `x`=300, `y`=200, between clock edges). Outputs return to the reset values before the next edge, and counting resumes from 0 after release.
- Override parameters to WIDTH=8, HEIGHT=4 with porches 1/2/1 and 1/1/1. H_TOTAL is 12 and V_TOTAL is 7, and all sync and active windows scale accordingly.
